// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// cam_pkg : shared types and constants for the DVP camera capture engine
// Rev 1.0
// ============================================================================
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2
  } cam_state_e;

  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;
  localparam int FRAME_PIX = IMG_W_DEF * IMG_H_DEF;

  // First sensor byte of a pixel lands in the upper bits of dout.
  localparam bit MSB_FIRST = 1'b1;

  function automatic int frame_pix(input int w, input int h);
    return w * h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_sync_edge.sv
`default_nettype none
// ============================================================================
// cam_sync_edge : registers a level and flags its rising/falling transitions
// Rev 1.0
// ============================================================================
module cam_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_q;
  logic din_d;

  assign din_d = din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_q <= 1'b0;
    else        din_q <= din_d;
  end

  assign rise = din & ~din_q;
  assign fall = ~din & din_q;

endmodule
`default_nettype wire

// File: rtl/cam_capture_ctrl.sv
`default_nettype none
// ============================================================================
// cam_capture_ctrl : DVP sensor capture, pixel assembly and linear addressing
// Rev 1.0
// ============================================================================
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int IMG_W         = IMG_W_DEF,
  parameter int IMG_H         = IMG_H_DEF,
  parameter int BYTES_PER_PIX = 2,
  parameter int ADDR_W        = 17,
  parameter bit VSYNC_POL     = 1'b1
) (
  input  logic                       pclk,
  input  logic                       rst_n,
  input  logic                       cap_start,
  input  logic                       cap_mode,
  input  logic                       vsync,
  input  logic                       href,
  input  logic [7:0]                 d,
  output logic                       we,
  output logic [ADDR_W-1:0]          addr,
  output logic [8*BYTES_PER_PIX-1:0] dout,
  output logic                       busy,
  output logic                       frame_done,
  output logic [7:0]                 frame_cnt,
  output logic                       line_err,
  output logic                       short_err
);

  localparam int   FRAME_PIXELS = frame_pix(IMG_W, IMG_H);
  localparam int   DW           = 8 * BYTES_PER_PIX;
  localparam int   COL_W        = $clog2(IMG_W + 1);
  localparam int   LINE_W       = $clog2(IMG_H + 1);
  localparam logic PH_LAST      = 1'(BYTES_PER_PIX - 1);

  cam_state_e state_q, state_d;

  logic vs, vs_rise, vs_fall;
  logic href_rise, href_fall;
  logic busy_w, cap_begin_w, cap_end_w;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     dout_q, dout_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              line_err_q, line_err_d;
  logic              short_err_q, short_err_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic              line_wrote_q, line_wrote_d;
  logic              phase_q, phase_d;
  logic [7:0]        byte_q, byte_d;
  logic              phase_w;
  logic [15:0]       lat_w;
  logic [DW-1:0]     pix_w;

  assign vs = (vsync == VSYNC_POL);

  cam_sync_edge u_vs_edge (
    .clk   (pclk),
    .rst_n (rst_n),
    .din   (vs),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );

  cam_sync_edge u_href_edge (
    .clk   (pclk),
    .rst_n (rst_n),
    .din   (href),
    .rise  (href_rise),
    .fall  (href_fall)
  );

  // Pending byte plus the byte on the bus form the 16-bit assembly latch.
  assign lat_w = {byte_q, d};

  generate
    if (BYTES_PER_PIX == 2) begin : g_pix16
      assign pix_w = MSB_FIRST ? lat_w : {lat_w[7:0], lat_w[15:8]};
    end else begin : g_pix8
      assign pix_w = lat_w[7:0];
    end
  endgenerate

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cap_start) state_d = ST_WAIT_VS;
      ST_WAIT_VS: if (vs_fall)   state_d = ST_CAPTURE;
      ST_CAPTURE: if (vs_rise)   state_d = cap_mode ? ST_WAIT_VS : ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_w      = 1'b0;
    cap_begin_w = 1'b0;
    cap_end_w   = 1'b0;
    case (state_q)
      ST_WAIT_VS: begin
        busy_w      = 1'b1;
        cap_begin_w = vs_fall;
      end
      ST_CAPTURE: begin
        busy_w    = 1'b1;
        cap_end_w = vs_rise;
      end
      default: ;
    endcase
  end

  always_comb begin
    we_d         = 1'b0;
    addr_d       = addr_q;
    dout_d       = dout_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    line_err_d   = line_err_q;
    short_err_d  = short_err_q;
    col_d        = col_q;
    line_d       = line_q;
    line_base_d  = line_base_q;
    line_wrote_d = line_wrote_q;
    phase_d      = phase_q;
    byte_d       = byte_q;
    phase_w      = phase_q;

    if (cap_begin_w) begin
      addr_d       = '0;
      line_err_d   = 1'b0;
      short_err_d  = 1'b0;
      col_d        = '0;
      line_d       = '0;
      line_base_d  = '0;
      line_wrote_d = 1'b0;
      phase_d      = 1'b0;
    end else if (state_q == ST_CAPTURE) begin
      if (href) begin
        phase_w = href_rise ? 1'b0 : phase_q;
        byte_d  = d;
        if (phase_w == PH_LAST) begin
          phase_d = 1'b0;
          if (line_q >= LINE_W'(IMG_H) || col_q >= COL_W'(IMG_W)) begin
            line_err_d = 1'b1;
          end else begin
            we_d         = 1'b1;
            dout_d       = pix_w;
            addr_d       = line_base_q + ADDR_W'(col_q);
            col_d        = col_q + 1'b1;
            line_wrote_d = 1'b1;
          end
        end else begin
          phase_d = phase_w + 1'b1;
        end
      end else if (href_fall) begin
        if (phase_q != 1'b0) line_err_d = 1'b1;
        phase_d      = 1'b0;
        col_d        = '0;
        line_wrote_d = 1'b0;
        if (line_wrote_q) begin
          line_d      = line_q + 1'b1;
          line_base_d = line_base_q + ADDR_W'(IMG_W);
        end
      end

      // Uses line_d so a line closing on the frame-end edge still counts.
      if (cap_end_w) begin
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 8'd1;
        if (line_d < LINE_W'(IMG_H)) short_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      addr_q       <= '0;
      dout_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
      line_err_q   <= 1'b0;
      short_err_q  <= 1'b0;
      col_q        <= '0;
      line_q       <= '0;
      line_base_q  <= '0;
      line_wrote_q <= 1'b0;
      phase_q      <= 1'b0;
      byte_q       <= 8'd0;
    end else begin
      we_q         <= we_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      line_err_q   <= line_err_d;
      short_err_q  <= short_err_d;
      col_q        <= col_d;
      line_q       <= line_d;
      line_base_q  <= line_base_d;
      line_wrote_q <= line_wrote_d;
      phase_q      <= phase_d;
      byte_q       <= byte_d;
    end
  end

  assign we         = we_q;
  assign addr       = addr_q;
  assign dout       = dout_q;
  assign busy       = busy_w;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign line_err   = line_err_q;
  assign short_err  = short_err_q;

  // The address range must cover every pixel of the frame.
  generate
    if ((2 ** ADDR_W) < FRAME_PIXELS) begin : g_addr_too_narrow
      logic addr_w_too_small;
      assign addr_w_too_small = 1'b1;
    end
  endgenerate

endmodule
`default_nettype wire
